change_dispenser: RTL and testbench
===================================

CHANGE_DISPENSER -- requirements
Module: change_dispenser

Interface
REQ-001 Parameter: INIT_STOCK, default 4'd8, coins of each denomination loaded at reset.
REQ-002 Parameter: STOCK_MAX, default 4'd15, coins of each denomination loaded on refill.
REQ-003 Port: CLK  input  1  single clock; all state updates on posedge CLK.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: req  input  1  change request; sampled only in IDLE.
REQ-006 Port: amount  input  4  change owed in rubles (0..15); latched with req.
REQ-007 Port: coin_ack  input  1  hopper has released the currently presented coin.
REQ-008 Port: refill  input  1  restock all tubes; honoured only in IDLE.
REQ-009 Port: coin_5  output  1  dispense one 5-ruble coin; held until ack.
REQ-010 Port: coin_2  output  1  dispense one 2-ruble coin; held until ack.
REQ-011 Port: coin_1  output  1  dispense one 1-ruble coin; held until ack.
REQ-012 Port: busy  output  1  high in every state except IDLE.
REQ-013 Port: done  output  1  one-cycle pulse: full amount paid out.
REQ-014 Port: short  output  1  one-cycle pulse: stock cannot cover remaining amount.
REQ-015 Port: owed  output  4  remaining unpaid rubles; valid while busy and during the short pulse.
REQ-016 Port: stock_5, stock_2, stock_1  output  4 each  current coin count per tube.

Function
REQ-017 FSM states SHALL be IDLE, SEL, DISP, DONE, FAULT; all transitions on posedge CLK.
REQ-018 IDLE: req=1 SHALL latch amount into owed and go to SEL; req=0 stays in IDLE.
REQ-019 SEL: owed=0 SHALL go to DONE.
REQ-020 SEL: otherwise SHALL register the largest denomination d in {5,2,1} with d<=owed and stock_d>0, then go to DISP.
REQ-021 SEL: if no denomination qualifies, SHALL go to FAULT.
REQ-022 DISP: exactly one of coin_5/coin_2/coin_1 (the registered d) SHALL be high; all three are low in every other state.
REQ-023 DISP, coin_ack=0: SHALL stay in DISP with the same coin line held.
REQ-024 DISP, coin_ack=1: SHALL set owed-=d and stock_d-=1, then go to SEL.
REQ-025 coin_ack outside DISP SHALL be ignored.
REQ-026 DONE: done=1 for exactly one cycle, then IDLE.
REQ-027 FAULT: short=1 for exactly one cycle with owed holding the unpaid residue, then IDLE; owed is not cleared by the fault.
REQ-028 Selection is greedy with no backtracking (e.g. owed=3, stock_1=0 -> one 2-ruble coin, then FAULT with owed=1).
REQ-029 req asserted while busy=1 SHALL be ignored; no queuing.
REQ-030 refill in IDLE SHALL set all three stocks to STOCK_MAX next cycle.
REQ-031 refill outside IDLE SHALL be ignored.
REQ-032 req and refill together in IDLE: refill applies and the request starts in the same cycle; selection uses the refilled stock.
REQ-033 Arithmetic is 4-bit unsigned; owed and stock SHALL never underflow, guaranteed by the SEL qualification rule.
REQ-034 Latency: req to first coin line = 2 cycles; each ack to the next coin line = 2 cycles; last ack to done = 2 cycles; amount=0 gives done 2 cycles after req.

Reset
REQ-035 reset=1 SHALL force state IDLE, owed=0, stock_5=stock_2=stock_1=INIT_STOCK and all coin/done/short/busy outputs 0 at the next edge.
REQ-036 reset has priority over every other input.
REQ-037 reset mid-dispense SHALL abort the payout; the coin line drops at that edge and the stock decrement for the unacknowledged coin is lost.

Verification
REQ-038 Reset, then req with amount=7, coin_ack tied high -> coin_5 pulse, then coin_2 pulse, done 6 cycles after req; stock_5=7, stock_2=7, stock_1=8.
REQ-039 amount=9, coin_ack delayed 3 cycles per coin -> coin_5 held 4 cycles, then coin_2 twice; done; owed=0.
REQ-040 Deplete stock_5 to 0, then amount=5 -> two coin_2 and one coin_1 dispensed, done.
REQ-041 stock_2=stock_1=0, amount=3 -> no coin line asserted; short pulse with owed=3; state returns to IDLE.
REQ-042 req at the same time as refill in IDLE with stock_5=0, amount=5 -> stocks become 15, then one coin_5, done; a second req during busy is ignored.
REQ-043 reset asserted while coin_2 is held -> next cycle: all outputs 0, stocks=INIT_STOCK, busy=0.

Source files
------------

// File: rtl/change_dispenser.sv
// change_dispenser: greedy 5/2/1-ruble change payout FSM with per-denomination coin stock
module change_dispenser #(
  parameter logic [3:0] INIT_STOCK = 4'd8,
  parameter logic [3:0] STOCK_MAX = 4'd15
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic       req,
  input  logic [3:0] amount,
  input  logic       coin_ack,
  input  logic       refill,
  output logic       coin_5,
  output logic       coin_2,
  output logic       coin_1,
  output logic       busy,
  output logic       done,
  output logic       short,
  output logic [3:0] owed,
  output logic [3:0] stock_5,
  output logic [3:0] stock_2,
  output logic [3:0] stock_1
);
  typedef enum logic [2:0] {IDLE, SEL, DISP, DONE, FAULT} state_t;
  state_t state, state_n;
  logic [2:0] coin, pick;
  logic [3:0] value;
  always_comb begin
    pick = (owed >= 4'd5 && stock_5 != 4'd0) ? 3'b100 :
           (owed >= 4'd2 && stock_2 != 4'd0) ? 3'b010 :
           (owed >= 4'd1 && stock_1 != 4'd0) ? 3'b001 : 3'b000;
    value = coin[2] ? 4'd5 : coin[1] ? 4'd2 : 4'd1;
    state_n = state;
    case (state)
      IDLE:    state_n = req ? SEL : IDLE;
      SEL:     state_n = owed == 4'd0 ? DONE : pick != 3'b000 ? DISP : FAULT;
      DISP:    state_n = coin_ack ? SEL : DISP;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (reset) begin
      state <= IDLE;
      owed <= 4'd0;
      coin <= 3'b000;
      stock_5 <= INIT_STOCK;
      stock_2 <= INIT_STOCK;
      stock_1 <= INIT_STOCK;
    end else begin
      state <= state_n;
      if (state == IDLE && refill) begin
        stock_5 <= STOCK_MAX;
        stock_2 <= STOCK_MAX;
        stock_1 <= STOCK_MAX;
      end
      if (state == IDLE && req) owed <= amount;
      if (state == SEL) coin <= pick;
      if (state == DISP && coin_ack) begin
        owed <= owed - value;
        if (coin[2]) stock_5 <= stock_5 - 4'd1;
        if (coin[1]) stock_2 <= stock_2 - 4'd1;
        if (coin[0]) stock_1 <= stock_1 - 4'd1;
      end
    end
  end
  assign coin_5 = state == DISP && coin[2];
  assign coin_2 = state == DISP && coin[1];
  assign coin_1 = state == DISP && coin[0];
  assign busy = state != IDLE;
  assign done = state == DONE;
  assign short = state == FAULT;
endmodule

// File: tb/tb_change_dispenser.sv
// tb_change_dispenser: directed scoreboard bench; expected coin sequences come from a greedy stock model
module tb_change_dispenser;
  logic CLK = 1'b0, reset = 1'b1, req = 1'b0, coin_ack = 1'b0, refill = 1'b0;
  logic [3:0] amount = 4'd0;
  logic coin_5, coin_2, coin_1, busy, done, short;
  logic [3:0] owed, stock_5, stock_2, stock_1;
  int checks = 0, errors = 0;
  int exp_q[$];
  int m5, m2, m1, first_k, last_k;

  always #5 CLK = ~CLK;

  change_dispenser dut (
    .CLK(CLK), .reset(reset), .req(req), .amount(amount), .coin_ack(coin_ack), .refill(refill),
    .coin_5(coin_5), .coin_2(coin_2), .coin_1(coin_1), .busy(busy), .done(done), .short(short),
    .owed(owed), .stock_5(stock_5), .stock_2(stock_2), .stock_1(stock_1)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, want);
    end
  endtask

  function automatic int line_val();
    return coin_5 ? 5 : coin_2 ? 2 : coin_1 ? 1 : 0;
  endfunction

  task automatic model(input int amt, input bit rf);
    int o = amt;
    if (rf) begin m5 = 15; m2 = 15; m1 = 15; end
    while (o > 0) begin
      if (o >= 5 && m5 > 0) begin exp_q.push_back(5); o -= 5; m5--; end
      else if (o >= 2 && m2 > 0) begin exp_q.push_back(2); o -= 2; m2--; end
      else if (o >= 1 && m1 > 0) begin exp_q.push_back(1); o -= 1; m1--; end
      else break;
    end
    exp_q.push_back(o == 0 ? 0 : 100 + o);
  endtask

  task automatic check_stock();
    chk("stock_5", {4'd0, stock_5}, 8'(m5));
    chk("stock_2", {4'd0, stock_2}, 8'(m2));
    chk("stock_1", {4'd0, stock_1}, 8'(m1));
  endtask

  task automatic run(input int amt, input int dly, input bit rf, input bit noise);
    int k, got, want;
    model(amt, rf);
    first_k = -1;
    last_k = -1;
    @(negedge CLK);
    req = 1'b1; amount = 4'(amt); refill = rf;
    @(negedge CLK);
    req = 1'b0; refill = 1'b0; k = 1;
    if (noise) begin
      req = 1'b1; refill = 1'b1; amount = 4'hf;
      @(negedge CLK);
      req = 1'b0; refill = 1'b0; k = 2;
    end
    forever begin
      if (k > 80) begin chk("timeout", 8'd1, 8'd0); break; end
      got = line_val();
      if (got != 0) begin
        if (first_k < 0) first_k = k;
        chk("onehot", 8'(int'(coin_5) + int'(coin_2) + int'(coin_1)), 8'd1);
        chk("busy_disp", {7'd0, busy}, 8'd1);
        want = exp_q.size() > 0 ? exp_q.pop_front() : 255;
        chk("coin", 8'(got), 8'(want));
        for (int i = 0; i < dly; i++) begin
          @(negedge CLK); k++;
          chk("coin_held", 8'(line_val()), 8'(got));
        end
        coin_ack = 1'b1;
        @(negedge CLK); k++;
        coin_ack = 1'b0;
      end else if (done || short) begin
        last_k = k;
        want = exp_q.size() > 0 ? exp_q.pop_front() : 255;
        chk("outcome", done ? 8'd0 : 8'(100 + int'(owed)), 8'(want));
        if (done) chk("owed_done", {4'd0, owed}, 8'd0);
        @(negedge CLK);
        chk("pulse_done", {7'd0, done}, 8'd0);
        chk("pulse_short", {7'd0, short}, 8'd0);
        chk("idle_busy", {7'd0, busy}, 8'd0);
        break;
      end else begin
        @(negedge CLK); k++;
      end
    end
    chk("queue_left", 8'(exp_q.size()), 8'd0);
    exp_q.delete();
    check_stock();
  endtask

  initial begin
    m5 = 8; m2 = 8; m1 = 8;
    repeat (2) @(negedge CLK);
    chk("rst_busy", {7'd0, busy}, 8'd0);
    chk("rst_done", {7'd0, done}, 8'd0);
    chk("rst_short", {7'd0, short}, 8'd0);
    chk("rst_coins", {5'd0, coin_5, coin_2, coin_1}, 8'd0);
    chk("rst_owed", {4'd0, owed}, 8'd0);
    check_stock();
    reset = 1'b0;
    coin_ack = 1'b1;
    repeat (3) @(negedge CLK);
    coin_ack = 1'b0;
    chk("ack_idle_busy", {7'd0, busy}, 8'd0);
    check_stock();
    run(7, 0, 1'b0, 1'b0);
    chk("lat_first_coin", 8'(first_k), 8'd2);
    chk("lat_done", 8'(last_k), 8'd6);
    run(9, 3, 1'b0, 1'b1);
    run(0, 0, 1'b0, 1'b0);
    chk("lat_zero", 8'(last_k), 8'd2);
    run(15, 0, 1'b0, 1'b0);
    run(15, 0, 1'b0, 1'b0);
    chk("stock5_empty", {4'd0, stock_5}, 8'd0);
    run(5, 1, 1'b0, 1'b0);
    for (int i = 0; i < 20 && (m2 > 0 || m1 > 0); i++) run(4, 0, 1'b0, 1'b0);
    run(3, 0, 1'b0, 1'b0);
    chk("short_first", 8'(first_k), 8'hff);
    run(5, 0, 1'b1, 1'b1);
    for (int i = 0; i < 15; i++) run(1, 0, 1'b0, 1'b0);
    run(3, 0, 1'b0, 1'b0);
    @(negedge CLK);
    req = 1'b1; amount = 4'd2;
    @(negedge CLK);
    req = 1'b0;
    for (int i = 0; i < 10 && !coin_2; i++) @(negedge CLK);
    chk("coin2_seen", {7'd0, coin_2}, 8'd1);
    reset = 1'b1;
    @(negedge CLK);
    reset = 1'b0;
    m5 = 8; m2 = 8; m1 = 8;
    chk("abort_coins", {5'd0, coin_5, coin_2, coin_1}, 8'd0);
    chk("abort_busy", {7'd0, busy}, 8'd0);
    chk("abort_flags", {6'd0, done, short}, 8'd0);
    chk("abort_owed", {4'd0, owed}, 8'd0);
    check_stock();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
